// File: rtl/cap_demux_expand_if.sv
// ---------------------------------------------------------------------------
// cap_demux_expand_if
//  Handshake and data bundle for the capacitor-to-channel expansion block.
//  Input side:  in_valid/in_ready with cap_data, sw and ch_mask.
//  Output side: out_valid/out_ready with ch_data, map_cnt, err_short and
//               err_excess.
//  Modports:
//   master : the environment. It drives the input word and out_ready.
//   slave  : the expansion block itself.
// ---------------------------------------------------------------------------
interface cap_demux_expand_if #(
    parameter int CHANNEL_NUM   = 128,
    parameter int CAPACITOR_NUM = 70,
    parameter int CNT_W         = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CAPACITOR_NUM-1:0] cap_data;
    logic [CAPACITOR_NUM-1:0] sw;
    logic [CHANNEL_NUM-1:0]   ch_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic [CHANNEL_NUM-1:0]   ch_data;
    logic [CNT_W-1:0]         map_cnt;
    logic                     err_short;
    logic                     err_excess;

    modport master (
        output in_valid, cap_data, sw, ch_mask, out_ready,
        input  in_ready, out_valid, ch_data, map_cnt, err_short, err_excess
    );

    modport slave (
        input  in_valid, cap_data, sw, ch_mask, out_ready,
        output in_ready, out_valid, ch_data, map_cnt, err_short, err_excess
    );
endinterface

// File: rtl/cap_demux_expand.sv
// ---------------------------------------------------------------------------
// cap_demux_expand
//  This block is the receive-side inverse of the channel-to-capacitor
//  compaction. It scatters one capacitor sample word back onto the channel
//  lanes. The k-th set bit of sw, counted in capacitor order, lands on the
//  k-th set bit of ch_mask, counted in channel order. The block is
//  iterative and handles one channel per clock.
//  Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cap_demux_expand_if.slave. It carries the in_valid/in_ready
//           word input and the out_valid/out_ready result output with
//           the map count and error flags.
// ---------------------------------------------------------------------------
module cap_demux_expand #(
    parameter int CHANNEL_NUM   = 128,
    parameter int CAPACITOR_NUM = 70,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cap_demux_expand_if.slave    bus
);
    localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(CHANNEL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [PTR_W-1:0]         ch_ptr;
    logic [CAPACITOR_NUM-1:0] cap_q;
    logic [CAPACITOR_NUM-1:0] sw_rem;
    logic [CHANNEL_NUM-1:0]   mask_q;
    logic [CHANNEL_NUM-1:0]   ch_data_q;
    logic [CNT_W-1:0]         map_cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     err_short_q;
    logic                     err_excess_q;

    // The next capacitor to consume is always the lowest remaining set bit
    // of sw_rem. Two's-complement isolation finds that one-hot bit without
    // a priority encoder. The data bit is then the OR of cap_q masked by it.
    logic [CAPACITOR_NUM-1:0] low_bit;
    logic [CAPACITOR_NUM-1:0] sw_step;
    logic                     take;
    logic                     cap_bit;

    always_comb begin
        low_bit = sw_rem & (~sw_rem + CAPACITOR_NUM'(1));
        take    = mask_q[ch_ptr];
        cap_bit = |(cap_q & low_bit);
        // sw_rem & (sw_rem - 1) clears the lowest set bit. A zero sw_rem
        // stays zero, so this step is safe even when the scan is short.
        sw_step = take ? (sw_rem & (sw_rem - CAPACITOR_NUM'(1))) : sw_rem;
    end

    // NOTE: every register here, data words included, is reset. A reset in
    // the middle of a scan must leave no trace of the discarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch_ptr       <= '0;
            cap_q        <= '0;
            sw_rem       <= '0;
            mask_q       <= '0;
            ch_data_q    <= '0;
            map_cnt_q    <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_excess_q <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking. Every branch then
            // reads the values from before this edge, whatever the order.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cap_q        <= bus.cap_data;
                        sw_rem       <= bus.sw;
                        mask_q       <= bus.ch_mask;
                        ch_data_q    <= '0;
                        map_cnt_q    <= '0;
                        err_short_q  <= 1'b0;
                        err_excess_q <= 1'b0;
                        ch_ptr       <= '0;
                        in_ready_q   <= 1'b0;
                        state        <= SCAN;
                    end
                end

                SCAN: begin
                    sw_rem <= sw_step;
                    if (take) begin
                        if (sw_rem != '0) begin
                            ch_data_q[ch_ptr] <= cap_bit;
                            map_cnt_q         <= map_cnt_q + CNT_W'(1);
                        end else begin
                            // The channel wanted a capacitor but none are left.
                            // The lane stays 0 from the clear done at accept.
                            err_short_q <= 1'b1;
                        end
                    end
                    if (ch_ptr == LAST_CH) begin
                        err_excess_q <= (sw_step != '0);
                        state        <= DONE;
                    end else begin
                        ch_ptr <= ch_ptr + PTR_W'(1);
                    end
                end

                DONE: begin
                    // out_valid rises on the first DONE cycle. That places it
                    // CHANNEL_NUM+1 edges after the accepting edge.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ch_data    = ch_data_q;
    assign bus.map_cnt    = map_cnt_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_excess = err_excess_q;

endmodule
